csi_frame_ctrl: RTL and testbench

//  Frame-capture sequencer for the CSI receive packet handler. Holds the packet handler
//  in reset until software arms a capture, then aligns to a clean frame start, gates
//  the payload stream for exactly one frame (or continuously), and counts lines/words.

---
 rtl/csi_frame_ctrl.sv | 218 +++++++++++++++++++++
 tb/tb_csi_frame_ctrl.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csi_frame_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : csi_frame_ctrl
//  Purpose  : Frame-capture sequencer for the CSI receive packet handler.
//             Holds the handler in reset until a capture is armed, aligns to
//             a clean frame start and gates the payload for one frame, or
//             for every frame in continuous mode. Counts lines and words, and
//             flags inactivity timeouts, header ECC errors and line overflow.
//  Revision : 1.0  initial release
// ============================================================================
module csi_frame_ctrl #(
    parameter int LINE_CNT_W  = 12,
    parameter int WORD_CNT_W  = 24,
    parameter int TIMEOUT_W   = 16,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic                  rxbyteclkhs_i,
    input  logic                  reset_n_i,
    input  logic                  arm_i,
    input  logic                  abort_i,
    input  logic                  continuous_i,
    input  logic                  frame_active_i,
    input  logic                  frame_valid_i,
    input  logic                  hdr_err_i,
    output logic                  pckt_rst_o,
    output logic                  capture_en_o,
    output logic                  busy_o,
    output logic                  frame_done_o,
    output logic                  frame_err_o,
    output logic [1:0]            err_code_o,
    output logic [LINE_CNT_W-1:0] line_count_o,
    output logic [WORD_CNT_W-1:0] word_count_o
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SKIP    = 3'd1,
        ST_WAIT_FS = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_DONE    = 3'd4,
        ST_ERROR   = 3'd5
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_TIMEOUT = 2'd1;
    localparam logic [1:0] ERR_HDR     = 2'd2;
    localparam logic [1:0] ERR_OVF     = 2'd3;

    localparam logic [TIMEOUT_W-1:0]  TO_LIMIT = TIMEOUT_W'(TIMEOUT_CYC - 1);
    localparam logic [TIMEOUT_W-1:0]  TO_ONE   = TIMEOUT_W'(1);
    localparam logic [LINE_CNT_W-1:0] LINE_MAX = '1;
    localparam logic [LINE_CNT_W-1:0] LINE_ONE = LINE_CNT_W'(1);
    localparam logic [WORD_CNT_W-1:0] WORD_MAX = '1;
    localparam logic [WORD_CNT_W-1:0] WORD_ONE = WORD_CNT_W'(1);

    state_t                  state_q, state_d;
    logic [1:0]              err_code_q, err_code_d;
    logic [LINE_CNT_W-1:0]   line_q, line_d;
    logic [WORD_CNT_W-1:0]   word_q, word_d;
    logic [TIMEOUT_W-1:0]    to_q, to_d;
    logic                    fa_prev_q;
    logic                    fv_prev_q;
    logic                    pckt_rst_q;
    logic                    busy_q;
    logic                    done_q;
    logic                    err_q;

    logic                    in_capture;
    logic                    timed_state;
    logic                    activity;
    logic                    timeout_hit;
    logic                    line_inc;
    logic                    line_ovf;
    logic                    word_inc;
    logic                    clear_counts;

    // Event decode shared by the FSM, counters and the inactivity timer
    always_comb begin
        in_capture  = (state_q == ST_CAPTURE);
        timed_state = (state_q == ST_SKIP) || (state_q == ST_WAIT_FS) || in_capture;
        // Any payload word or frame_active edge counts as link activity
        activity    = frame_valid_i | (frame_active_i ^ fa_prev_q);
        timeout_hit = timed_state & ~activity & (to_q == TO_LIMIT);
        // A line ends on the falling edge of frame_valid, or when the frame
        // closes while a line is still open
        line_inc    = in_capture & ((fv_prev_q & ~frame_valid_i) |
                                    (~frame_active_i & frame_valid_i));
        line_ovf    = line_inc & (line_q == LINE_MAX);
        word_inc    = in_capture & frame_valid_i;
    end

    // Next-state and error-code selection; abort overrides everything
    always_comb begin
        state_d      = state_q;
        err_code_d   = err_code_q;
        clear_counts = 1'b0;
        if (abort_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (arm_i) begin
                        err_code_d = ERR_NONE;
                        state_d    = frame_active_i ? ST_SKIP : ST_WAIT_FS;
                    end
                end
                ST_SKIP: begin
                    if (!frame_active_i) begin
                        state_d = ST_WAIT_FS;
                    end else if (timeout_hit) begin
                        state_d    = ST_ERROR;
                        err_code_d = ERR_TIMEOUT;
                    end
                end
                ST_WAIT_FS: begin
                    if (frame_active_i) begin
                        state_d      = ST_CAPTURE;
                        clear_counts = 1'b1;
                    end else if (timeout_hit) begin
                        state_d    = ST_ERROR;
                        err_code_d = ERR_TIMEOUT;
                    end
                end
                ST_CAPTURE: begin
                    if (hdr_err_i) begin
                        state_d    = ST_ERROR;
                        err_code_d = ERR_HDR;
                    end else if (line_ovf) begin
                        state_d    = ST_ERROR;
                        err_code_d = ERR_OVF;
                    end else if (!frame_active_i) begin
                        state_d = ST_DONE;
                    end else if (timeout_hit) begin
                        state_d    = ST_ERROR;
                        err_code_d = ERR_TIMEOUT;
                    end
                end
                ST_DONE: begin
                    state_d = continuous_i ? ST_WAIT_FS : ST_IDLE;
                end
                ST_ERROR: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Saturating line/word counters; frozen while abort is asserted
    always_comb begin
        line_d = line_q;
        word_d = word_q;
        if (clear_counts) begin
            line_d = '0;
            word_d = '0;
        end else if (!abort_i) begin
            if (word_inc && (word_q != WORD_MAX)) begin
                word_d = word_q + WORD_ONE;
            end
            if (line_inc && !line_ovf) begin
                line_d = line_q + LINE_ONE;
            end
        end
    end

    // Inactivity timer restarts on every state change and on link activity
    always_comb begin
        if ((state_d != state_q) || activity || !timed_state) begin
            to_d = '0;
        end else begin
            to_d = to_q + TO_ONE;
        end
    end

    // State, counters and registered outputs
    always_ff @(posedge rxbyteclkhs_i) begin
        if (!reset_n_i) begin
            state_q    <= ST_IDLE;
            err_code_q <= ERR_NONE;
            line_q     <= '0;
            word_q     <= '0;
            to_q       <= '0;
            fa_prev_q  <= 1'b0;
            fv_prev_q  <= 1'b0;
            pckt_rst_q <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            err_code_q <= err_code_d;
            line_q     <= line_d;
            word_q     <= word_d;
            to_q       <= to_d;
            fa_prev_q  <= frame_active_i;
            // Only track line edges seen while capturing, so stale
            // frame_valid from before the frame start is never counted
            fv_prev_q  <= frame_valid_i & in_capture;
            pckt_rst_q <= (state_d == ST_IDLE) || (state_d == ST_ERROR);
            busy_q     <= (state_d != ST_IDLE);
            done_q     <= (state_d == ST_DONE);
            err_q      <= (state_d == ST_ERROR);
        end
    end

    assign capture_en_o = frame_valid_i & in_capture;
    assign pckt_rst_o   = pckt_rst_q;
    assign busy_o       = busy_q;
    assign frame_done_o = done_q;
    assign frame_err_o  = err_q;
    assign err_code_o   = err_code_q;
    assign line_count_o = line_q;
    assign word_count_o = word_q;

endmodule
`default_nettype wire

// File: tb/tb_csi_frame_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_csi_frame_ctrl
//  Purpose  : Scoreboard bench for csi_frame_ctrl. Frames are described as
//             line/word lists; the expected outcome of each frame is derived
//             from those lists and queued, and a monitor compares it with the
//             done/err pulse the design presents.
//  Revision : 1.0  initial release
// ============================================================================
module tb_csi_frame_ctrl;

    localparam int LW = 2;
    localparam int WW = 8;
    localparam int TW = 8;
    localparam int TC = 20;
    localparam int WORD_SAT = (1 << WW) - 1;
    localparam int LINE_SAT = (1 << LW) - 1;

    logic clk = 1'b0;
    logic rst_n, arm, abort, cont, fa, fv, hdr;
    logic pckt_rst, capture_en, busy, done, err;
    logic [1:0]    err_code;
    logic [LW-1:0] line_count;
    logic [WW-1:0] word_count;

    always #5 clk = ~clk;

    csi_frame_ctrl #(
        .LINE_CNT_W (LW),
        .WORD_CNT_W (WW),
        .TIMEOUT_W  (TW),
        .TIMEOUT_CYC(TC)
    ) dut (
        .rxbyteclkhs_i (clk),
        .reset_n_i     (rst_n),
        .arm_i         (arm),
        .abort_i       (abort),
        .continuous_i  (cont),
        .frame_active_i(fa),
        .frame_valid_i (fv),
        .hdr_err_i     (hdr),
        .pckt_rst_o    (pckt_rst),
        .capture_en_o  (capture_en),
        .busy_o        (busy),
        .frame_done_o  (done),
        .frame_err_o   (err),
        .err_code_o    (err_code),
        .line_count_o  (line_count),
        .word_count_o  (word_count)
    );

    typedef struct {
        bit is_err;
        int code;
        int lines;
        int words;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   last_line = 0;
    int   last_word = 0;
    int   line_w[8];
    bit   prev_pulse = 1'b0;
    bit   busy_watch = 1'b0;
    bit   busy_drop  = 1'b0;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, req);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: outcome of a frame from its line list
    task automatic expect_frame(input int nl, input int hdr_at, input int abort_at);
        int cum, done_lines, total, stop_at;
        exp_t e;
        total = 0;
        for (int l = 0; l < nl; l++) total += line_w[l];
        stop_at = (abort_at >= 0) ? abort_at : hdr_at;
        if (stop_at >= 0) begin
            cum = 0;
            done_lines = 0;
            for (int l = 0; l < nl; l++) begin
                cum += line_w[l];
                if (cum <= stop_at) done_lines++;
            end
            last_line = done_lines;
            last_word = (abort_at >= 0) ? abort_at : hdr_at + 1;
            if (abort_at < 0) begin
                e = '{1'b1, 2, last_line, last_word};
                exp_q.push_back(e);
            end
        end else begin
            last_word = (total > WORD_SAT) ? WORD_SAT : total;
            if (nl > LINE_SAT) begin
                last_line = LINE_SAT;
                e = '{1'b1, 3, last_line, last_word};
            end else begin
                last_line = nl;
                e = '{1'b0, 0, last_line, last_word};
            end
            exp_q.push_back(e);
        end
    endtask

    task automatic do_arm(input int idle);
        tick(); arm = 1'b1;
        tick(); arm = 1'b0;
        repeat (idle) tick();
    endtask

    // Drive one frame from line_w; cap says whether the DUT should be gating
    task automatic drive_frame(input int nl, input bit end_hi, input bit cap,
                               input int hdr_at, input int abort_at);
        int idx;
        int g;
        bit capt;
        idx  = 0;
        capt = cap;
        tick(); fa = 1'b1; fv = 1'b0;
        g = $urandom_range(1, 3);
        repeat (g - 1) tick();
        for (int l = 0; l < nl; l++) begin
            for (int k = 0; k < line_w[l]; k++) begin
                tick();
                fv    = 1'b1;
                hdr   = (idx == hdr_at);
                abort = (idx == abort_at);
                if (end_hi && (l == nl - 1) && (k == line_w[l] - 1)) fa = 1'b0;
                #1 check("capture_en", int'(capture_en), int'(capt));
                if ((idx == hdr_at) || (idx == abort_at)) capt = 1'b0;
                idx++;
            end
            tick(); fv = 1'b0; hdr = 1'b0; abort = 1'b0;
            if (l == nl - 1) begin
                if (!end_hi) begin
                    g = $urandom_range(0, 2);
                    repeat (g) tick();
                    fa = 1'b0;
                end
            end else begin
                g = $urandom_range(1, 3);
                repeat (g - 1) tick();
            end
        end
    endtask

    // Monitor: every done/err pulse is matched against the scoreboard head
    always @(negedge clk) begin
        if (rst_n) begin
            if (busy_watch && !busy) busy_drop = 1'b1;
            if (done || err) begin
                check("pulse_single_cycle", int'(prev_pulse), 0);
                if (exp_q.size() == 0) begin
                    check("pulse_expected", 0, 1);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("pulse_err",      int'(err),        int'(mon_e.is_err));
                    check("pulse_done",     int'(done),       int'(!mon_e.is_err));
                    check("err_code",       int'(err_code),   mon_e.code);
                    check("line_count",     int'(line_count), mon_e.lines);
                    check("word_count",     int'(word_count), mon_e.words);
                    check("pulse_pckt_rst", int'(pckt_rst),   int'(mon_e.is_err));
                    check("pulse_busy",     int'(busy),       1);
                end
            end
            prev_pulse = done | err;
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n, nl, total, hdr_at;
        bit end_hi;
        rst_n = 1'b0; arm = 1'b0; abort = 1'b0; cont = 1'b0;
        fa = 1'b0; fv = 1'b0; hdr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_pckt_rst",   int'(pckt_rst),   1);
        check("rst_busy",       int'(busy),       0);
        check("rst_done",       int'(done),       0);
        check("rst_err",        int'(err),        0);
        check("rst_err_code",   int'(err_code),   0);
        check("rst_line_count", int'(line_count), 0);
        check("rst_word_count", int'(word_count), 0);
        rst_n = 1'b1;
        tick();

        // Single 3x8 frame after 10 idle cycles
        do_arm(10);
        line_w[0] = 8; line_w[1] = 8; line_w[2] = 8;
        expect_frame(3, -1, -1);
        drive_frame(3, 1'b0, 1'b1, -1, -1);
        repeat (4) tick();
        check("idle_pckt_rst", int'(pckt_rst), 1);
        check("idle_busy",     int'(busy),     0);

        // Arm mid-frame: skip it (header error there is ignored), take next
        tick(); fa = 1'b1;
        for (int l = 0; l < 3; l++) begin
            for (int k = 0; k < 4; k++) begin
                tick();
                fv  = 1'b1;
                arm = (l == 0) && (k == 1);
                hdr = (l == 1) && (k == 2);
                if (l > 0) begin
                    #1 check("skip_capture_en", int'(capture_en), 0);
                end
            end
            tick(); fv = 1'b0; arm = 1'b0; hdr = 1'b0;
        end
        check("skip_busy",     int'(busy),     1);
        check("skip_pckt_rst", int'(pckt_rst), 0);
        tick(); fa = 1'b0;
        repeat (2) tick();
        line_w[0] = 4; line_w[1] = 4;
        expect_frame(2, -1, -1);
        drive_frame(2, 1'b0, 1'b1, -1, -1);
        repeat (4) tick();

        // Continuous mode: two back-to-back 2x4 frames
        cont = 1'b1;
        do_arm(2);
        busy_watch = 1'b1;
        for (int f = 0; f < 2; f++) begin
            expect_frame(2, -1, -1);
            drive_frame(2, 1'b0, 1'b1, -1, -1);
            repeat (3) tick();
        end
        busy_watch = 1'b0;
        check("cont_busy_held", int'(busy_drop), 0);
        abort = 1'b1;
        tick(); abort = 1'b0; cont = 1'b0;
        tick();
        check("abort_from_wait_busy", int'(busy), 0);

        // Header error during line 2, then re-arm clears err_code
        do_arm(3);
        line_w[0] = 6; line_w[1] = 6; line_w[2] = 6;
        expect_frame(3, 8, -1);
        drive_frame(3, 1'b0, 1'b1, 8, -1);
        repeat (4) tick();
        check("hdr_err_code_held", int'(err_code), 2);
        do_arm(0);
        check("arm_clears_err_code", int'(err_code), 0);
        line_w[0] = 3;
        expect_frame(1, -1, -1);
        drive_frame(1, 1'b0, 1'b1, -1, -1);
        repeat (4) tick();

        // Timeout with no frame: counts held from the previous frame
        exp_q.push_back('{1'b1, 1, last_line, last_word});
        tick(); arm = 1'b1;
        tick(); arm = 1'b0;
        n = 0;
        while (!err && n < 100) begin
            tick();
            n++;
        end
        check("timeout_latency", n, TC);
        repeat (3) tick();

        // Abort during capture after 5 words
        do_arm(1);
        line_w[0] = 8;
        expect_frame(1, -1, 5);
        drive_frame(1, 1'b0, 1'b1, -1, 5);
        repeat (2) tick();
        check("abort_busy",       int'(busy),       0);
        check("abort_pckt_rst",   int'(pckt_rst),   1);
        check("abort_word_count", int'(word_count), last_word);
        check("abort_line_count", int'(line_count), last_line);
        check("abort_err_code",   int'(err_code),   0);
        repeat (2) tick();

        // Line counter overflow: 4 lines into a 2-bit counter
        do_arm(0);
        line_w[0] = 2; line_w[1] = 3; line_w[2] = 2; line_w[3] = 3;
        expect_frame(4, -1, -1);
        drive_frame(4, 1'b0, 1'b1, -1, -1);
        repeat (4) tick();

        // Word counter saturation, frame closing with frame_valid high
        do_arm(0);
        line_w[0] = 300;
        expect_frame(1, -1, -1);
        drive_frame(1, 1'b1, 1'b1, -1, -1);
        repeat (4) tick();

        // Randomized single-shot frames
        for (int r = 0; r < 15; r++) begin
            nl = $urandom_range(1, 4);
            total = 0;
            for (int l = 0; l < nl; l++) begin
                line_w[l] = $urandom_range(1, 10);
                total += line_w[l];
            end
            hdr_at = -1;
            if (($urandom_range(0, 3) == 0) && (total > 1)) hdr_at = $urandom_range(0, total - 2);
            end_hi = 1'($urandom_range(0, 1));
            do_arm($urandom_range(0, 10));
            expect_frame(nl, hdr_at, -1);
            drive_frame(nl, end_hi, 1'b1, hdr_at, -1);
            repeat (4) tick();
        end

        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            tick();
            n++;
        end
        check("scoreboard_drained", int'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
